// File: rtl/traffic_signal_monitor.sv
// -----------------------------------------------------------------------------
// traffic_signal_monitor
//
// Receiver-side monitor for a two-approach traffic controller. The light codes
// of both approaches (0 = red, 1 = yellow, 2 = green, 3 = illegal) are
// registered and decoded into one-hot lamp drives. Each cycle the monitor also
// checks for the following faults:
//   - illegal codes
//   - conflicting greens
//   - illegal colour sequences
//   - yellows that are too short
// Any violation latches a fault and forces both approaches to red until the
// fault is acknowledged while both inputs are red.
//
// Optional feature macro: TSM_FLASH_EN
//   defined   -> red lamps flash while in FAULT (half-period FLASH_DIV cycles)
//   undefined -> red lamps are steady while in FAULT, no flash logic is built
//
// Parameters:
//   MIN_YELLOW  minimum consecutive yellow cycles before yellow->red
//   FLASH_DIV   cycles per half-period of the fault red flash
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   a, b        approach A / B light codes
//   fault_clr   fault acknowledge (level)
//   lamps_a/b   {red, yellow, green} lamp drives, one-hot or all-off
//   fault       latched fault flag
//   fault_code  first fault cause: 0 none, 1 illegal code, 2 conflict,
//               3 bad sequence, 4 short yellow
//   fault_side  bit0 = approach A implicated, bit1 = approach B implicated
// -----------------------------------------------------------------------------
module traffic_signal_monitor #(
    parameter int MIN_YELLOW = 2,
    parameter int FLASH_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       fault_clr,
    output logic [2:0] lamps_a,
    output logic [2:0] lamps_b,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_side
);

    localparam logic [1:0] ST_ARM   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_BADSEQ  = 3'd3;
    localparam logic [2:0] CODE_SHORTY  = 3'd4;

    localparam logic [2:0] LAMP_RED = 3'b100;

    logic [1:0] r_state;
    logic [1:0] r_aQ, r_bQ;
    logic [1:0] r_aP, r_bP;
    logic [7:0] r_dwellA, r_dwellB;
    logic [2:0] r_lampsA, r_lampsB;
    logic       r_fault;
    logic [2:0] r_faultCode;
    logic [1:0] r_faultSide;

    logic [1:0] w_illegalSide;
    logic       w_conflict;
    logic [1:0] w_badSeqSide;
    logic [1:0] w_shortSide;
    logic [2:0] w_detCode;
    logic [1:0] w_detSide;
    logic       w_enterFault;
    logic       w_clearFault;
    logic [2:0] w_faultRed;

    // Only red->green, green->yellow and yellow->red are legal changes;
    // holding the same code is always legal.
    function automatic logic legalStep(input logic [1:0] prev, input logic [1:0] cur);
        case ({prev, cur})
            4'b00_10, 4'b10_01, 4'b01_00: legalStep = 1'b1;
            default:                      legalStep = (prev == cur);
        endcase
    endfunction

    function automatic logic [2:0] decodeLamp(input logic [1:0] code);
        case (code)
            2'd0:    decodeLamp = 3'b100;
            2'd1:    decodeLamp = 3'b010;
            2'd2:    decodeLamp = 3'b001;
            default: decodeLamp = 3'b000;
        endcase
    endfunction

    // The dwell count describes how long the code now moving into a_p/b_p has
    // been held, saturating so long greens never wrap.
    function automatic logic [7:0] nextDwell(input logic [1:0] prev, input logic [1:0] cur,
                                             input logic [7:0] dwell);
        if (prev != cur) begin
            nextDwell = 8'd1;
        end else if (dwell == 8'hFF) begin
            nextDwell = dwell;
        end else begin
            nextDwell = dwell + 8'd1;
        end
    endfunction

    assign w_illegalSide = {r_bQ == 2'd3, r_aQ == 2'd3};
    assign w_conflict    = (r_aQ != 2'd0) && (r_bQ != 2'd0);
    assign w_badSeqSide  = {~legalStep(r_bP, r_bQ), ~legalStep(r_aP, r_aQ)};
    assign w_shortSide   = {(r_bP == 2'd1) && (r_bQ == 2'd0) && (r_dwellB < 8'(MIN_YELLOW)),
                            (r_aP == 2'd1) && (r_aQ == 2'd0) && (r_dwellA < 8'(MIN_YELLOW))};

    // Priority-ordered fault detection. In ARM the a_p/b_p baseline is not yet
    // valid, so only the checks that look at the current codes alone apply.
    always_comb begin
        w_detCode = CODE_NONE;
        w_detSide = 2'b00;
        if (w_illegalSide != 2'b00) begin
            w_detCode = CODE_ILLEGAL;
            w_detSide = w_illegalSide;
        end else if (w_conflict) begin
            w_detCode = CODE_CONFLICT;
            w_detSide = 2'b11;
        end else if (r_state == ST_RUN) begin
            if (w_badSeqSide != 2'b00) begin
                w_detCode = CODE_BADSEQ;
                w_detSide = w_badSeqSide;
            end else if (w_shortSide != 2'b00) begin
                w_detCode = CODE_SHORTY;
                w_detSide = w_shortSide;
            end
        end
    end

    assign w_enterFault = (r_state != ST_FAULT) && (w_detCode != CODE_NONE);
    assign w_clearFault = (r_state == ST_FAULT) && fault_clr && (r_aQ == 2'd0) && (r_bQ == 2'd0);

`ifdef TSM_FLASH_EN
    localparam int FLASH_CW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    logic [FLASH_CW-1:0] r_flashCnt;
    logic                r_flashPhase;
    logic                w_flashWrap;

    assign w_flashWrap = (r_flashCnt == FLASH_CW'(FLASH_DIV - 1));

    // Flash timebase restarts on every fault entry so the red lamp is always
    // lit for a full half-period first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flashCnt   <= '0;
            r_flashPhase <= 1'b1;
        end else if (w_enterFault) begin
            r_flashCnt   <= '0;
            r_flashPhase <= 1'b1;
        end else if (r_state == ST_FAULT) begin
            if (w_flashWrap) begin
                r_flashCnt   <= '0;
                r_flashPhase <= ~r_flashPhase;
            end else begin
                r_flashCnt <= r_flashCnt + 1'b1;
            end
        end
    end

    // The lamp register loads the phase value the flash logic is moving to,
    // so lamps and phase change on the same edge.
    assign w_faultRed = {w_flashWrap ? ~r_flashPhase : r_flashPhase, 2'b00};
`else
    logic w_unusedFlashDiv;

    // Without flashing the divider has no effect; the red stays steady.
    assign w_unusedFlashDiv = (FLASH_DIV > 1);
    assign w_faultRed       = LAMP_RED;
`endif

    // Input stage, previous-code history and dwell counters. These run in every
    // state; ARM re-seeds the dwell counters so a fresh run starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aQ     <= 2'd0;
            r_bQ     <= 2'd0;
            r_aP     <= 2'd0;
            r_bP     <= 2'd0;
            r_dwellA <= 8'd0;
            r_dwellB <= 8'd0;
        end else begin
            r_aQ <= a;
            r_bQ <= b;
            r_aP <= r_aQ;
            r_bP <= r_bQ;
            if (r_state == ST_ARM) begin
                r_dwellA <= 8'd1;
                r_dwellB <= 8'd1;
            end else begin
                r_dwellA <= nextDwell(r_aP, r_aQ, r_dwellA);
                r_dwellB <= nextDwell(r_bP, r_bQ, r_dwellB);
            end
        end
    end

    // Monitor FSM plus registered lamp and fault outputs. A detected violation
    // goes straight to red at the same edge it is captured, so an illegal
    // combination is never shown on the lamps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ARM;
            r_lampsA    <= LAMP_RED;
            r_lampsB    <= LAMP_RED;
            r_fault     <= 1'b0;
            r_faultCode <= CODE_NONE;
            r_faultSide <= 2'b00;
        end else begin
            case (r_state)
                ST_ARM, ST_RUN: begin
                    if (w_enterFault) begin
                        r_state     <= ST_FAULT;
                        r_fault     <= 1'b1;
                        r_faultCode <= w_detCode;
                        r_faultSide <= w_detSide;
                        r_lampsA    <= LAMP_RED;
                        r_lampsB    <= LAMP_RED;
                    end else if (r_state == ST_ARM) begin
                        r_state  <= ST_RUN;
                        r_lampsA <= LAMP_RED;
                        r_lampsB <= LAMP_RED;
                    end else begin
                        r_lampsA <= decodeLamp(r_aQ);
                        r_lampsB <= decodeLamp(r_bQ);
                    end
                end
                ST_FAULT: begin
                    if (w_clearFault) begin
                        r_state     <= ST_ARM;
                        r_fault     <= 1'b0;
                        r_faultCode <= CODE_NONE;
                        r_faultSide <= 2'b00;
                        r_lampsA    <= LAMP_RED;
                        r_lampsB    <= LAMP_RED;
                    end else begin
                        r_lampsA <= w_faultRed;
                        r_lampsB <= w_faultRed;
                    end
                end
                default: begin
                    r_state  <= ST_ARM;
                    r_lampsA <= LAMP_RED;
                    r_lampsB <= LAMP_RED;
                end
            endcase
        end
    end

    assign lamps_a    = r_lampsA;
    assign lamps_b    = r_lampsB;
    assign fault      = r_fault;
    assign fault_code = r_faultCode;
    assign fault_side = r_faultSide;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_signal_monitor
//
// Directed bench for traffic_signal_monitor. A behavioural model keeps the
// sampled code history since the last arming, and derives the expected lamps
// and fault outputs from the colour rules. Every cycle, a compare process
// checks the DUT against that model. Literal checks at key points pin the
// model's answers.
// -----------------------------------------------------------------------------
module tb_traffic_signal_monitor;

    localparam int MIN_YELLOW = 2;
    localparam int FLASH_DIV  = 4;
`ifdef TSM_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif
    localparam logic [2:0] LAMP_AFTER_HALF = FLASH_ON ? 3'b000 : 3'b100;

    typedef enum {M_ARM, M_RUN, M_FAULT} modeT;
    typedef logic [1:0] histT[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] a, b;
    logic       fault_clr;
    logic [2:0] lamps_a, lamps_b;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_side;

    int vectors     = 0;
    int miscompares = 0;

    traffic_signal_monitor #(
        .MIN_YELLOW(MIN_YELLOW),
        .FLASH_DIV (FLASH_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .fault_clr (fault_clr),
        .lamps_a   (lamps_a),
        .lamps_b   (lamps_b),
        .fault     (fault),
        .fault_code(fault_code),
        .fault_side(fault_side)
    );

    always #5 clk = ~clk;

    // Model state: sampled codes, history since arming, expected outputs.
    modeT       mMode;
    logic [1:0] mQa, mQb;
    histT       histA, histB;
    int         mAge;
    logic [2:0] eLa, eLb, eCode;
    logic       eFault;
    logic [1:0] eSide;
    logic [2:0] mCode;
    logic [1:0] mSide;
    bit         modelReady = 1'b0;
    logic [2:0] lampTable[4] = '{3'b100, 3'b010, 3'b001, 3'b000};
    logic [1:0] successor[4] = '{2'd2, 2'd0, 2'd1, 2'd3};

    function automatic logic isLegal(input logic [1:0] p, input logic [1:0] c);
        if (p == c) return 1'b1;
        if (p == 2'd3) return 1'b0;
        return c == successor[p];
    endfunction

    function automatic int yellowRun(input histT h);
        int n = 0;
        for (int i = h.size() - 1; i >= 0; i--) begin
            if (h[i] != 2'd1) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic shortYellow(input histT h, input logic [1:0] cur);
        if (h.size() == 0) return 1'b0;
        return (h[h.size() - 1] == 2'd1) && (cur == 2'd0) && (yellowRun(h) < MIN_YELLOW);
    endfunction

    // Behavioural model: evaluated on the rising edge from the pre-edge inputs
    // and the model's own copy of the sampled codes.
    always @(posedge clk) begin
        if (rst) begin
            mMode  = M_ARM;
            mQa    = 2'd0;
            mQb    = 2'd0;
            histA.delete();
            histB.delete();
            eLa    = 3'b100;
            eLb    = 3'b100;
            eFault = 1'b0;
            eCode  = 3'd0;
            eSide  = 2'b00;
            mAge   = 0;
            modelReady = 1'b1;
        end else if (modelReady) begin
            mCode = 3'd0;
            mSide = 2'b00;
            if (mMode != M_FAULT) begin
                if (mQa == 2'd3 || mQb == 2'd3) begin
                    mCode = 3'd1;
                    mSide = {mQb == 2'd3, mQa == 2'd3};
                end else if (mQa != 2'd0 && mQb != 2'd0) begin
                    mCode = 3'd2;
                    mSide = 2'b11;
                end else if (mMode == M_RUN) begin
                    mSide = {!isLegal(histB[$], mQb), !isLegal(histA[$], mQa)};
                    if (mSide != 2'b00) begin
                        mCode = 3'd3;
                    end else begin
                        mSide = {shortYellow(histB, mQb), shortYellow(histA, mQa)};
                        if (mSide != 2'b00) mCode = 3'd4;
                    end
                end
            end

            if (mMode == M_ARM) begin
                histA.delete();
                histB.delete();
            end
            histA.push_back(mQa);
            histB.push_back(mQb);

            if (mMode != M_FAULT && mCode != 3'd0) begin
                mMode  = M_FAULT;
                eFault = 1'b1;
                eCode  = mCode;
                eSide  = mSide;
                mAge   = 0;
                eLa    = 3'b100;
                eLb    = 3'b100;
            end else if (mMode == M_ARM) begin
                mMode = M_RUN;
                eLa   = 3'b100;
                eLb   = 3'b100;
            end else if (mMode == M_RUN) begin
                eLa = lampTable[mQa];
                eLb = lampTable[mQb];
            end else if (fault_clr && mQa == 2'd0 && mQb == 2'd0) begin
                mMode  = M_ARM;
                eFault = 1'b0;
                eCode  = 3'd0;
                eSide  = 2'b00;
                eLa    = 3'b100;
                eLb    = 3'b100;
            end else begin
                mAge++;
                eLa = (!FLASH_ON || ((mAge / FLASH_DIV) % 2 == 0)) ? 3'b100 : 3'b000;
                eLb = eLa;
            end

            mQa = a;
            mQb = b;
        end
    end

    task automatic checkOutput(input string name, input int got, input int expected);
        vectors++;
        if (got != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, expected);
        end
    endtask

    // Cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("model lamps_a", lamps_a, eLa);
            checkOutput("model lamps_b", lamps_b, eLb);
            checkOutput("model fault", fault, eFault);
            checkOutput("model fault_code", fault_code, eCode);
            checkOutput("model fault_side", fault_side, eSide);
        end
    end

    task automatic applyStimulus(input logic [1:0] av, input logic [1:0] bv,
                                 input logic clr, input int cycles);
        a         = av;
        b         = bv;
        fault_clr = clr;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " lamps_a"}, lamps_a, 3'b100);
        checkOutput({tag, " lamps_b"}, lamps_b, 3'b100);
        checkOutput({tag, " fault"}, fault, 1'b0);
        checkOutput({tag, " fault_code"}, fault_code, 3'd0);
        checkOutput({tag, " fault_side"}, fault_side, 2'b00);
    endtask

    initial begin
        rst       = 1'b1;
        a         = 2'd0;
        b         = 2'd0;
        fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");

        // Green on A right after reset: ARM cycle keeps red, then green shows.
        rst = 1'b0;
        applyStimulus(2, 0, 0, 1);
        checkOutput("arm lamps_a", lamps_a, 3'b100);
        applyStimulus(2, 0, 0, 1);
        checkOutput("first lamps_a", lamps_a, 3'b001);
        checkOutput("first lamps_b", lamps_b, 3'b100);

        // Legal cycle on A, then on B.
        applyStimulus(2, 0, 0, 3);
        applyStimulus(1, 0, 0, 3);
        checkOutput("a yellow lamps", lamps_a, 3'b010);
        applyStimulus(0, 0, 0, 3);
        checkOutput("a red lamps", lamps_a, 3'b100);
        checkOutput("a cycle fault", fault, 1'b0);
        applyStimulus(0, 2, 0, 2);
        checkOutput("b green lamps", lamps_b, 3'b001);
        applyStimulus(0, 1, 0, 2);
        checkOutput("b yellow lamps", lamps_b, 3'b010);
        applyStimulus(0, 0, 0, 3);
        checkOutput("b red lamps", lamps_b, 3'b100);
        checkOutput("b cycle fault", fault, 1'b0);

        // Conflicting greens, then red flash behaviour.
        applyStimulus(2, 2, 0, 2);
        checkOutput("conflict fault", fault, 1'b1);
        checkOutput("conflict code", fault_code, 3'd2);
        checkOutput("conflict side", fault_side, 2'b11);
        checkOutput("conflict lamps_a", lamps_a, 3'b100);
        applyStimulus(2, 2, 0, 4);
        checkOutput("flash half lamps_a", lamps_a, LAMP_AFTER_HALF);
        applyStimulus(2, 2, 0, 4);
        checkOutput("flash full lamps_a", lamps_a, 3'b100);

        // Acknowledge is ignored unless both inputs are red.
        applyStimulus(2, 0, 1, 3);
        checkOutput("clr ignored fault", fault, 1'b1);
        checkOutput("clr ignored code", fault_code, 3'd2);
        applyStimulus(0, 0, 1, 2);
        checkOutput("clr fault", fault, 1'b0);
        checkOutput("clr code", fault_code, 3'd0);
        checkOutput("clr side", fault_side, 2'b00);
        applyStimulus(0, 0, 0, 2);

        // Yellow back to green on A.
        applyStimulus(2, 0, 0, 2);
        applyStimulus(1, 0, 0, 2);
        applyStimulus(2, 0, 0, 2);
        checkOutput("badseq code", fault_code, 3'd3);
        checkOutput("badseq side", fault_side, 2'b01);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 0, 2);
        checkOutput("badseq cleared", fault, 1'b0);

        // Illegal code on B never reaches the lamps.
        applyStimulus(0, 3, 0, 2);
        checkOutput("illegal code", fault_code, 3'd1);
        checkOutput("illegal side", fault_side, 2'b10);
        checkOutput("illegal lamps_b", lamps_b, 3'b100);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 0, 2);

        // One-cycle yellow on A.
        applyStimulus(2, 0, 0, 2);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 2);
        checkOutput("short yellow code", fault_code, 3'd4);
        checkOutput("short yellow side", fault_side, 2'b01);

        // Reset in the middle of a fault.
        rst = 1'b1;
        applyStimulus(2, 0, 0, 1);
        checkResetValues("mid-fault reset");
        rst = 1'b0;
        applyStimulus(2, 0, 0, 2);
        checkOutput("post reset lamps_a", lamps_a, 3'b001);
        checkOutput("post reset fault", fault, 1'b0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_signal_monitor.md
# traffic_signal_monitor

Receiver-side monitor for the two-approach traffic controller's light-code outputs. It samples the approach codes `a` and `b` (0 = red, 1 = yellow, 2 = green) and decodes them into one-hot lamp drives. It also checks every cycle for illegal codes, conflicting greens, illegal colour sequences and short yellows. On any violation it latches a fault and forces both approaches to (flashing) red until cleared.

## Interface

Parameters:
- MIN_YELLOW, default 2: minimum consecutive yellow cycles required before a yellow-to-red transition.
- FLASH_DIV, default 4: cycles per half-period of the fault red flash.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  2  approach A light code from the controller.
- b  input  2  approach B light code from the controller.
- fault_clr  input  1  fault acknowledge; level-sampled.
- lamps_a  output  3  approach A lamps {red, yellow, green}, one-hot or all-off.
- lamps_b  output  3  approach B lamps, same encoding.
- fault  output  1  latched fault flag.
- fault_code  output  3  first fault cause: 0 none, 1 ILLEGAL_CODE, 2 CONFLICT, 3 BAD_SEQ, 4 SHORT_YELLOW.
- fault_side  output  2  bit0 = approach A implicated, bit1 = approach B implicated.

## Operation

- Input stage: `a` and `b` are registered into `a_q`/`b_q` every cycle. All checks use `a_q`/`b_q` and the previous values `a_p`/`b_p`.
- Dwell counters: one 8-bit counter per approach counts consecutive cycles at the current code.
  - Set to 1 when the code changes.
  - Incremented when the code holds.
  - Saturates at 255.
- FSM states: ARM, RUN, FAULT.
  - ARM: entered from reset. Lasts exactly one cycle. Loads the `a_p`/`b_p` baseline and sets both dwell counters to 1. Only the ILLEGAL_CODE and CONFLICT checks are active. Lamps stay red. Goes to RUN if no fault is detected, otherwise to FAULT.
  - RUN: all checks are active. Lamps decode `a_q`/`b_q`: 0 gives 100, 1 gives 010, 2 gives 001.
  - FAULT: `fault` = 1, and `fault_code`/`fault_side` hold their captured values. Lamp drive depends on `TSM_FLASH_EN` (see Configuration). Leaves to ARM only when `fault_clr` = 1 and `a_q` = `b_q` = 0 in the same cycle; `fault_clr` is otherwise ignored. On that exit, `fault`, `fault_code` and `fault_side` clear at the same edge.
- Checks, in priority order; the highest-priority violation detected in a cycle is captured:
  1. ILLEGAL_CODE: `a_q` or `b_q` equals 3.
  2. CONFLICT: `a_q` ≠ 0 and `b_q` ≠ 0 (both approaches non-red).
  3. BAD_SEQ: a code change other than red→green, green→yellow or yellow→red.
  4. SHORT_YELLOW: a yellow→red change while the previous yellow dwell is less than MIN_YELLOW.
- `fault_side` marks every approach failing the captured check. CONFLICT always sets it to 11.
- Later violations while in FAULT do not overwrite `fault_code` or `fault_side`.

## Timing

- Reset values: `lamps_a` = `lamps_b` = 100, `fault` = 0, `fault_code` = 0, `fault_side` = 00, state = ARM, `a_q` = `b_q` = 0, dwell counters = 0, flash counter = 0, flash phase = 1.
- Latency: an input change at edge N appears in `a_q` at edge N; lamps update at edge N+1 (2-cycle input-to-lamp).
- Violations in `a_q`/`b_q` registered at edge N:
  - `fault`, `fault_code`, `fault_side` and the forced-red lamps all appear at edge N+1.
  - The illegal state never reaches the lamps.
- `rst` overrides everything, including the FAULT state, with reset values at the next edge.
- A `fault_clr` arriving in the same cycle as a new violation is a simultaneous event: the exit condition requires all-red inputs, so no violation can exist in that cycle.
- Flash timing: on FAULT entry the flash counter is set to 0 and the phase to 1 (red on). The phase toggles each time the counter wraps at FLASH_DIV−1, giving a period of 2·FLASH_DIV cycles.

## Configuration

- `TSM_FLASH_EN` defined: in FAULT, both approaches drive {phase, 0, 0}, i.e. red flashes per the timing above.
- `TSM_FLASH_EN` undefined: in FAULT, both approaches drive steady 100. The flash counter and phase logic are not built.

## Test plan

- Reset, then hold `a` = 2, `b` = 0: two cycles after the first sample, `lamps_a` = 001 and `lamps_b` = 100, with `fault` = 0 throughout.
- Legal sequence: `a` G×5 → Y×3 → R, then `b` R→G→Y×2→R: lamps follow with 2-cycle latency and `fault` stays 0.
- Drive `a` = 2, `b` = 2 in RUN: next cycle `fault` = 1, `fault_code` = 2, `fault_side` = 11. With `TSM_FLASH_EN`, both lamps toggle 100/000 every 4 cycles.
- `a` Y→G, and separately `b` = 3: first gives `fault_code` = 3, `fault_side` = 01; second gives `fault_code` = 1, `fault_side` = 10.
- `a` G→Y for 1 cycle then R (MIN_YELLOW = 2): `fault_code` = 4, `fault_side` = 01.
- In FAULT, `fault_clr` = 1 with `a` = 2: stays in FAULT. Then `fault_clr` = 1 with `a` = `b` = 0: `fault` = 0 next cycle, one ARM cycle, then RUN. Asserting `rst` mid-FAULT also clears all outputs to their reset values.
